// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared formats, opcodes and range helper for the immediate encoder
package imm_pkg;

    typedef enum logic [1:0] {
        FMT_ILOAD = 2'd0,
        FMT_S     = 2'd1,
        FMT_SB    = 2'd2,
        FMT_IALU  = 2'd3
    } fmt_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    // True when the 64-bit value is a sign-extended 12-bit immediate.
    function automatic logic fits_s12(input logic [63:0] imm);
        return imm[63:11] == {53{imm[11]}};
    endfunction

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - combinational field packer: format/fields/immediate to instruction word
module imm_pack
    import imm_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [63:0] imm,
    output logic [31:0] instr,
    output logic        in_range
);

    logic [11:0] i;

    always_comb begin
        i        = imm[11:0];
        in_range = fits_s12(imm);
        instr    = '0;
        unique case (fmt)
            FMT_ILOAD: instr = {i[11:0], rs1, funct3, rd, OP_LOAD};
            FMT_IALU:  instr = {i[11:0], rs1, funct3, rd, OP_IMM};
            FMT_S:     instr = {i[11:5], rs2, rs1, funct3, i[4:0], OP_STORE};
            // SB immediate is already halfword-scaled, so i[0] lands in instr[8].
            FMT_SB:    instr = {i[11], i[9:4], rs2, rs1, funct3, i[3:0], i[10], OP_BRANCH};
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - one-deep output stage, address counter and range-error counter around imm_pack
module imm_encoder
    import imm_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_range,
    output logic [ERR_W-1:0]  err_count
);

    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ERR_W-1:0]  errc_q, errc_d;

    logic [31:0]       pk_instr;
    logic              pk_range;
    logic              accept;
    logic              good;
    logic              bad;
    logic [ADDR_W-1:0] base;

    imm_pack u_pack (
        .fmt      (fmt_e'(in_fmt)),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .funct3   (in_funct3),
        .imm      (in_imm),
        .instr    (pk_instr),
        .in_range (pk_range)
    );

    assign in_ready = !reset && (state_q == ST_EMPTY || out_ready);
    assign accept   = in_valid && in_ready;
    assign good     = accept && pk_range;
    assign bad      = accept && !pk_range;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        // clear takes effect before this cycle's accept picks its address
        base    = clear ? BASE_ADDR : cnt_q;
        cnt_d   = base;
        err_d   = bad;
        errc_d  = errc_q;

        if (good) begin
            state_d = ST_FULL;
            instr_d = pk_instr;
            addr_d  = base;
            cnt_d   = base + ADDR_W'(4);
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end

        if (clear) begin
            errc_d = bad ? ERR_W'(1) : '0;
        end else if (bad && errc_q != '1) begin
            errc_d = errc_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            instr_q <= '0;
            addr_q  <= BASE_ADDR;
            cnt_q   <= BASE_ADDR;
            err_q   <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            errc_q  <= errc_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign err_range = err_q;
    assign err_count = errc_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - directed and mixed vectors against a scoreboard model of imm_encoder
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, out_ready;
    logic        in_ready, out_valid, err_range;
    logic [1:0]  in_fmt;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [63:0] in_imm;
    logic [31:0] out_instr;
    logic [63:0] out_addr;
    logic [7:0]  err_count;

    imm_encoder #(.ADDR_W(64), .BASE_ADDR(64'h0), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_range(err_range), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] addr;
        logic [63:0] imm;
        bit          hl;
        logic [31:0] li;
        logic [63:0] la;
    } exp_t;

    exp_t        q[$];
    logic [63:0] m_addr = 64'h0;
    int unsigned m_errc = 0;
    bit          m_err = 1'b0;
    bit          run = 1'b0;
    bit          rnd_phase = 1'b0;
    bit          cur_hl = 1'b0;
    logic [31:0] cur_li = '0;
    logic [63:0] cur_la = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding written as field weights: each field value times its bit position weight.
    function automatic logic [31:0] enc(input int unsigned fmt, input int unsigned rd,
                                        input int unsigned rs1, input int unsigned rs2,
                                        input int unsigned f3, input logic [63:0] imm);
        int unsigned i12;
        int unsigned regs;
        i12  = int'(imm[11:0]);
        regs = rs1 * 32768 + f3 * 4096;
        case (fmt)
            0: return i12 * 1048576 + regs + rd * 128 + 3;
            3: return i12 * 1048576 + regs + rd * 128 + 19;
            1: return (i12 / 32) * 33554432 + rs2 * 1048576 + regs + (i12 % 32) * 128 + 35;
            default: return (i12 / 2048) * 32'h8000_0000 + ((i12 / 16) % 64) * 33554432
                          + rs2 * 1048576 + regs + (i12 % 16) * 256
                          + ((i12 / 1024) % 2) * 128 + 99;
        endcase
    endfunction

    function automatic bit in_rng(input logic [63:0] imm);
        longint s;
        s = imm;
        return s >= -2048 && s <= 2047;
    endfunction

    // Immediate generator: recovers the original sign-extended immediate from a word.
    function automatic logic [63:0] imm_gen(input logic [31:0] w);
        logic [11:0] v;
        case (w[6:0])
            7'h23:   v = {w[31:25], w[11:7]};
            7'h63:   v = {w[31], w[7], w[30:25], w[11:8]};
            default: v = w[31:20];
        endcase
        return {{52{v[11]}}, v};
    endfunction

    always @(negedge clk) begin
        if (run) begin
            bit   exp_rdy, acc, ok;
            exp_t e;
            logic [63:0] base;
            exp_rdy = !reset && (q.size() == 0 || out_ready);
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("out_instr", out_instr, q[0].instr);
                chk("out_addr", out_addr, q[0].addr);
                chk("round_trip", imm_gen(out_instr), q[0].imm);
                if (q[0].hl) begin
                    chk("lit_instr", out_instr, q[0].li);
                    chk("lit_addr", out_addr, q[0].la);
                end
            end
            chk("err_range", err_range, m_err);
            chk("err_count", err_count, m_errc);

            acc = in_valid && exp_rdy;
            ok  = in_rng(in_imm);
            if (reset) begin
                q.delete();
                m_addr = 64'h0;
                m_errc = 0;
                m_err  = 1'b0;
            end else begin
                base = clear ? 64'h0 : m_addr;
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                m_err  = acc && !ok;
                m_addr = base;
                if (acc && ok) begin
                    e.instr = enc(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
                    e.addr  = base;
                    e.imm   = in_imm;
                    e.hl    = cur_hl;
                    e.li    = cur_li;
                    e.la    = cur_la;
                    q.push_back(e);
                    m_addr = base + 64'd4;
                end
                if (clear) m_errc = (acc && !ok) ? 1 : 0;
                else if (acc && !ok && m_errc < 255) m_errc++;
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_phase) begin
            #1 out_ready = ($urandom % 4) != 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm,
                        input bit hl, input logic [31:0] li, input logic [63:0] la);
        bit done;
        done      = 1'b0;
        in_fmt    = f;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_imm    = imm;
        cur_hl    = hl;
        cur_li    = li;
        cur_la    = la;
        in_valid  = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        cur_hl   = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 64 cycles");
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
        @(posedge clk);
        #1;
        run = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_err_range", err_range, 0);
        chk("rst_err_count", err_count, 0);
        tick(1);

        send(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 64'd16, 1, 32'h01013283, 64'h0);
        send(2'd1, 5'd0, 5'd2, 5'd6, 3'd3, 64'd8, 1, 32'h00613423, 64'h4);
        send(2'd3, 5'd1, 5'd0, 5'd0, 3'd0, -64'sd1, 1, 32'hFFF00093, 64'h8);
        send(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, -64'sd2, 1, 32'hFE208EE3, 64'hC);
        tick(2);

        send(2'd3, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2048, 0, '0, '0);
        tick(2);
        chk("err_count_one", err_count, 1);
        send(2'd3, 5'd3, 5'd4, 5'd0, 3'd0, 64'd2047, 1, 32'h7FF20193, 64'h10);
        send(2'd1, 5'd0, 5'd0, 5'd0, 3'd0, -64'sd2048, 1, 32'h80000023, 64'h14);
        send(2'd1, 5'd0, 5'd0, 5'd0, 3'd0, -64'sd2049, 0, '0, '0);
        send(2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 64'h1000_0000_0000_0000, 0, '0, '0);
        tick(2);
        chk("err_count_three", err_count, 3);

        clear = 1'b1;
        send(2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 64'd5000, 0, '0, '0);
        clear = 1'b0;
        tick(1);
        chk("clear_err_count", err_count, 1);
        clear = 1'b1;
        send(2'd3, 5'd2, 5'd2, 5'd0, 3'd1, 64'd1, 1, 32'h00111113, 64'h0);
        clear = 1'b0;
        send(2'd3, 5'd2, 5'd2, 5'd0, 3'd1, 64'd2, 1, 32'h00211113, 64'h4);
        tick(2);

        out_ready = 1'b0;
        send(2'd0, 5'd7, 5'd8, 5'd0, 3'd2, 64'd100, 0, '0, '0);
        fork
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            send(2'd1, 5'd0, 5'd9, 5'd10, 3'd2, 64'd200, 0, '0, '0);
        join
        send(2'd2, 5'd0, 5'd11, 5'd12, 3'd1, -64'sd300, 0, '0, '0);
        tick(3);

        out_ready = 1'b0;
        send(2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 64'd4, 0, '0, '0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        tick(1);
        out_ready = 1'b1;
        send(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 64'd16, 1, 32'h01013283, 64'h0);
        tick(2);

        for (int k = 0; k < 260; k++) send(2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 64'd4096, 0, '0, '0);
        tick(2);
        chk("err_count_sat", err_count, 255);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;

        rnd_phase = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [31:0] r;
            logic [63:0] v;
            r = $urandom;
            v = {{52{r[11]}}, r[11:0]};
            if (r[31:29] == 3'd0) v = {$urandom, $urandom};
            send(r[13:12], r[18:14], r[23:19], r[28:24], r[2:0] ^ r[16:14], v, 0, '0, '0);
        end
        rnd_phase = 1'b0;
        #2 out_ready = 1'b1;
        tick(4);
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the pipeline's immediate generator: packs register fields and a 64-bit immediate into a 32-bit RV64 instruction word.
- Covers four formats: I-load, S-store, SB-branch, I-ALU.
- Feeds the instruction-memory loader and the self-check bench through a valid/ready stream, tagging each word with its byte address.
- Round-trip property: immediate generator applied to the emitted word returns the original in_imm.

Parameters:
ADDR_W, 64, width of out_addr / internal address counter
BASE_ADDR, 0, address of first emitted instruction and value after reset/clear
ERR_W, 8, width of saturating range-error counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
clear  input  1  synchronous; address counter := BASE_ADDR, err_count := 0; does not touch held output
in_valid  input  1  request valid
in_ready  output  1  encoder can accept this cycle
in_fmt  input  2  0=I-load, 1=S, 2=SB, 3=I-ALU
in_rd  input  5  destination reg (ignored for S/SB)
in_rs1  input  5  source reg 1
in_rs2  input  5  source reg 2 (ignored for I formats)
in_funct3  input  3  funct3 field
in_imm  input  64  sign-extended immediate; for SB, halfword-scaled offset (byte offset / 2)
out_valid  output  1  out_instr/out_addr valid
out_ready  input  1  downstream accepts
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  byte address of out_instr
err_range  output  1  one-cycle pulse: accepted request dropped, immediate out of range
err_count  output  ERR_W  saturating count of dropped requests

Behaviour:
- Reset: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_range=0, err_count=0, address counter=BASE_ADDR, state EMPTY.
- in_ready = (state==EMPTY) || out_ready; combinational; false during reset cycle.
- Accept = in_valid && in_ready.
- Range check, all formats: in_imm[63:11] all equal to in_imm[11] (signed 12-bit, -2048..2047).
- Opcodes: I-load 0000011, S 0100011, SB 1100011, I-ALU 0010011.
- Bit packing, with i = in_imm[11:0]:
  - I: {i[11:0], rs1, funct3, rd, op}
  - S: {i[11:5], rs2, rs1, funct3, i[4:0], op}
  - SB: {i[11], i[9:4], rs2, rs1, funct3, i[3:0], i[10], op}
- FSM with two states, EMPTY and FULL. Latency is 1 cycle: accept at edge N, out_valid high after edge N.
  - EMPTY + accept (in range) -> FULL; load out_instr; out_addr := counter; counter += 4.
  - FULL + out_ready && !accept -> EMPTY.
  - FULL + out_ready && accept (in range) -> stays FULL; new word loaded the same edge, no bubble.
  - FULL + !out_ready: out_instr/out_addr held stable; no accept.
- Out-of-range accept: word not emitted, counter unchanged, err_range=1 for the next cycle only, err_count += 1, saturating at all-ones. State follows the no-accept path.
- Counter wraps modulo 2^ADDR_W.
- clear concurrent with accept: the accepted word takes address BASE_ADDR; counter becomes BASE_ADDR+4.
- clear concurrent with a range error: err_count ends at 1.
- reset mid-transfer: held word discarded, out_valid=0 on the next cycle.
- in_fmt is always legal (2 bits), so there is no default opcode case.

Decomposition:
- Shared package imm_pkg:
  - format enum (FMT_ILOAD, FMT_S, FMT_SB, FMT_IALU)
  - the four opcode constants
  - immediate-generator opcode constants, reused by both blocks
- One combinational sub-module, imm_pack: fmt/fields/imm -> instr[31:0] and in_range. The sequential wrapper owns the FSM, address counter and error counter.

Test Plan:
- I-load rd=5 rs1=2 funct3=3 imm=16, out_ready=1 -> out_instr=0x01013283, out_addr=0x0.
- S rs2=6 rs1=2 funct3=3 imm=8 as second request -> 0x00613423, out_addr=0x4.
- I-ALU rd=1 rs1=0 funct3=0 imm=-1 -> 0xFFF00093.
- SB rs1=1 rs2=2 funct3=0 imm=-2 -> 0xFE208EE3.
- Round-trip: feed each output into the immediate generator -> returns the input in_imm exactly.
- I-ALU imm=2048 -> no out_valid, err_range pulses one cycle, err_count=1, next valid word gets the unchanged address.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> first word held stable and in_ready=0. Release -> words drain in order at consecutive addresses, no loss or duplication.
- Reset mid-transfer: reset while FULL -> out_valid=0 on the next cycle, next emitted word has out_addr=BASE_ADDR.
